// File: rtl/ofs_fim_eth_plat_if_pkg.sv
// Shared Ethernet platform types: AXI-S tuser payloads and TX bridge state.
package ofs_fim_eth_plat_if_pkg;

    localparam int unsigned ETH_PACKET_WIDTH         = 64;
    localparam int unsigned ETH_TX_ERROR_WIDTH       = 1;
    localparam int unsigned ETH_TX_USER_CLIENT_WIDTH = 2;

    // Bit positions inside the SS TX client field
    localparam int unsigned ETH_TX_CLIENT_ERR_BIT    = 0;
    localparam int unsigned ETH_TX_CLIENT_TRUNC_BIT  = 1;

    typedef struct packed {
        logic [ETH_TX_ERROR_WIDTH-1:0] error;
    } t_axis_eth_tx_tuser;

    typedef struct packed {
        logic [ETH_TX_USER_CLIENT_WIDTH-1:0] client;
    } t_axis_hssi_ss_tx_tuser;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } t_eth_tx_bridge_state;

endpackage

// File: rtl/ofs_fim_eth_tx_skid.sv
// Generic 2-entry AXI-S skid buffer: registered outputs, registered s_tready,
// one beat per clock sustained, one cycle of latency.
module ofs_fim_eth_tx_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata
);

    logic         r_m_valid;
    logic [W-1:0] r_m_data;
    logic         r_sk_valid;
    logic [W-1:0] r_sk_data;
    logic         r_s_ready;

    logic         w_in_fire;
    logic         w_out_free;
    logic         w_m_valid_nxt;
    logic         w_sk_valid_nxt;

    assign w_in_fire  = s_tvalid && r_s_ready;
    assign w_out_free = !r_m_valid || m_tready;

    // Occupancy update; the skid entry only fills while the output is stalled
    always_comb begin
        w_m_valid_nxt  = r_m_valid;
        w_sk_valid_nxt = r_sk_valid;
        if (w_out_free) begin
            if (r_sk_valid) begin
                w_m_valid_nxt  = 1'b1;
                w_sk_valid_nxt = 1'b0;
            end else begin
                w_m_valid_nxt  = w_in_fire;
            end
        end else if (w_in_fire) begin
            w_sk_valid_nxt = 1'b1;
        end
    end

    // Control flops; ready is a flop so m_tready never reaches s_tready combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid  <= 1'b0;
            r_sk_valid <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            r_m_valid  <= w_m_valid_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            r_s_ready  <= !w_sk_valid_nxt;
        end
    end

    // Payload flops; contents are don't-care while the matching valid is low
    always_ff @(posedge clk) begin
        if (w_out_free) begin
            r_m_data <= r_sk_valid ? r_sk_data : s_tdata;
        end
        if (!w_out_free && w_in_fire) begin
            r_sk_data <= s_tdata;
        end
    end

    assign s_tready = r_s_ready;
    assign m_tvalid = r_m_valid;
    assign m_tdata  = r_m_data;

endmodule

// File: rtl/ofs_fim_eth_tx_ss_bridge.sv
// TX bridge AFU AXI-S -> HSSI SS TX: error/truncation client bits, link gating
// at packet start, max-length truncation, registered output via skid buffer.
// Optional statistics counters enabled by defining ETH_TX_STATS_EN.
module ofs_fim_eth_tx_ss_bridge
    import ofs_fim_eth_plat_if_pkg::*;
#(
    parameter int unsigned DATA_W    = ETH_PACKET_WIDTH,
    parameter int unsigned MAX_BEATS = 192
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic [DATA_W-1:0]                   s_tdata,
    input  logic [DATA_W/8-1:0]                 s_tkeep,
    input  logic                                s_tlast,
    input  logic [ETH_TX_ERROR_WIDTH-1:0]       s_tuser_error,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [DATA_W-1:0]                   m_tdata,
    output logic [DATA_W/8-1:0]                 m_tkeep,
    output logic                                m_tlast,
    output logic [ETH_TX_USER_CLIENT_WIDTH-1:0] m_tuser_client,
    input  logic                                link_up,
    output logic [31:0]                         pkt_cnt,
    output logic [31:0]                         drop_cnt,
    output logic [31:0]                         trunc_cnt
);

    localparam int unsigned KEEP_W    = DATA_W / 8;
    localparam int unsigned PAYLOAD_W = DATA_W + KEEP_W + 1 + ETH_TX_USER_CLIENT_WIDTH;

    t_eth_tx_bridge_state   r_state;
    logic [15:0]            r_beat_cnt;
    logic                   r_err;

    t_axis_eth_tx_tuser     w_s_tuser;
    t_axis_hssi_ss_tx_tuser w_ss_tuser;
    t_axis_hssi_ss_tx_tuser w_m_tuser;
    logic                   w_skid_ready;
    logic                   w_fire;
    logic                   w_fwd;
    logic                   w_beat_err;
    logic                   w_is_max;
    logic                   w_m_tlast;
    logic [PAYLOAD_W-1:0]   w_skid_in;
    logic [PAYLOAD_W-1:0]   w_skid_out;

    assign w_s_tuser.error = s_tuser_error;
    assign w_beat_err      = |w_s_tuser.error;
    assign w_fire          = s_tvalid && w_skid_ready;
    assign s_tready        = w_skid_ready;
    // In PASS, the beat now on the input is beat number MAX_BEATS
    assign w_is_max        = (r_beat_cnt == 16'(MAX_BEATS - 1));

    // Per-beat forwarding decision and outgoing sideband
    always_comb begin
        w_fwd      = 1'b0;
        w_m_tlast  = s_tlast;
        w_ss_tuser = '0;
        case (r_state)
            IDLE: begin
                w_fwd = link_up;
                w_ss_tuser.client[ETH_TX_CLIENT_ERR_BIT] = w_beat_err;
            end
            PASS: begin
                w_fwd = 1'b1;
                w_ss_tuser.client[ETH_TX_CLIENT_ERR_BIT] = r_err || w_beat_err;
                if (!s_tlast && w_is_max) begin
                    w_m_tlast = 1'b1;
                    w_ss_tuser.client[ETH_TX_CLIENT_TRUNC_BIT] = 1'b1;
                end
            end
            default: begin
                w_fwd = 1'b0;
            end
        endcase
    end

    // Packet FSM, advanced only by accepted input beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= 16'd0;
            r_err      <= 1'b0;
        end else if (w_fire) begin
            case (r_state)
                IDLE: begin
                    r_beat_cnt <= 16'd0;
                    r_err      <= 1'b0;
                    if (!s_tlast) begin
                        if (link_up) begin
                            r_state    <= PASS;
                            r_beat_cnt <= 16'd1;
                            r_err      <= w_beat_err;
                        end else begin
                            r_state    <= DROP;
                        end
                    end
                end
                PASS: begin
                    if (s_tlast || w_is_max) begin
                        r_state    <= s_tlast ? IDLE : DROP;
                        r_beat_cnt <= 16'd0;
                        r_err      <= 1'b0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 16'd1;
                        r_err      <= r_err || w_beat_err;
                    end
                end
                DROP: begin
                    if (s_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_skid_in = {s_tdata, s_tkeep, w_m_tlast, w_ss_tuser};

    ofs_fim_eth_tx_skid #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid && w_fwd),
        .s_tready (w_skid_ready),
        .s_tdata  (w_skid_in),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (w_skid_out)
    );

    assign {m_tdata, m_tkeep, m_tlast, w_m_tuser} = w_skid_out;
    assign m_tuser_client = w_m_tuser.client;

`ifdef ETH_TX_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_drop_cnt;
    logic [31:0] r_trunc_cnt;
    logic        w_pkt_inc;
    logic        w_drop_inc;
    logic        w_trunc_inc;

    // Qualifying-beat decode for the statistics
    always_comb begin
        w_pkt_inc   = 1'b0;
        w_drop_inc  = 1'b0;
        w_trunc_inc = 1'b0;
        if (w_fire) begin
            case (r_state)
                IDLE: begin
                    w_pkt_inc  = link_up && s_tlast;
                    w_drop_inc = !link_up;
                end
                PASS: begin
                    w_pkt_inc   = s_tlast;
                    w_trunc_inc = !s_tlast && w_is_max;
                end
                default: begin
                    w_pkt_inc = 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt   <= 32'd0;
            r_drop_cnt  <= 32'd0;
            r_trunc_cnt <= 32'd0;
        end else begin
            if (w_pkt_inc && (r_pkt_cnt != 32'hFFFF_FFFF)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_drop_inc && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (w_trunc_inc && (r_trunc_cnt != 32'hFFFF_FFFF)) begin
                r_trunc_cnt <= r_trunc_cnt + 32'd1;
            end
        end
    end

    assign pkt_cnt   = r_pkt_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign trunc_cnt = r_trunc_cnt;
`else
    assign pkt_cnt   = 32'h0;
    assign drop_cnt  = 32'h0;
    assign trunc_cnt = 32'h0;
`endif

endmodule
